rgb2raw: RTL and testbench
==========================

RGB2RAW -- requirements
Module: rgb2raw

Interface
REQ-001 SHALL have parameter PW, default 8, bits per colour sample.
REQ-002 SHALL have parameter IN_PCNT, default 2, RGB pixels per input beat; OUT_PCNT SHALL be an integer multiple of IN_PCNT.
REQ-003 SHALL have parameter OUT_PCNT, default 4, raw samples per output beat.
REQ-004 SHALL have parameters MAX_HRES, default 1920, and MAX_VRES, default 1080; counter widths are $clog2 of each.
REQ-005 SHALL have parameter PATTERN, default "GBRG", one of RGGB, GRBG, GBRG, BGGR.
REQ-006 i_pclk  in  1  pixel clock; all logic rising-edge.
REQ-007 i_rstn  in  1  reset, asynchronous, active-low.
REQ-008 i_vsync, i_hsync, i_de, i_valid  in  1 each  video syncs and beat qualifier; i_valid implies i_de, i_de implies i_hsync, i_hsync implies i_vsync.
REQ-009 i_r, i_g, i_b  in  PW*IN_PCNT each  colour planes; pixel 0 in the low bits.
REQ-010 o_vsync, o_hsync, o_de  out  1 each  input syncs delayed exactly 2 cycles.
REQ-011 o_valid  out  1  packed raw word is valid.
REQ-012 o_raw  out  PW*OUT_PCNT  raw samples; first pixel in the low bits.
REQ-013 o_y_cnt  out  $clog2(MAX_VRES)  active-line index of the current output line.

Function
REQ-014 x counter SHALL count pixels: cleared while i_hsync low, +IN_PCNT on each i_de&&i_valid beat; pixel k of a beat has x = xcnt+k.
REQ-015 y counter SHALL clear while i_vsync low and increment on each i_de falling edge; the first active line is y=0.
REQ-016 Per pixel, the sample SHALL be chosen by {y[0], x[0]}: GBRG = (0,0)G (0,1)B (1,0)R (1,1)G; RGGB = R G / G B; GRBG = G R / B G; BGGR = B G / G R.
REQ-017 Gearbox SHALL place each beat's IN_PCNT samples at slot index beat_cnt*IN_PCNT, beat_cnt = 0..OUT_PCNT/IN_PCNT-1.
REQ-018 A beat that fills the last slot SHALL assert o_valid with the full word exactly 2 cycles after that beat, and SHALL reset beat_cnt to 0.
REQ-019 Beats with i_valid low SHALL not advance beat_cnt; gaps of any length inside a line SHALL be tolerated.
REQ-020 Flush: if i_de falls while beat_cnt != 0, the partial word SHALL be emitted with unfilled slots zero, o_valid high, 2 cycles after the last beat (o_de still high in that cycle).
REQ-021 o_valid SHALL never be high while o_de is low; at most one o_valid per completed or flushed word.
REQ-022 o_raw SHALL hold its last value when o_valid is low.
REQ-023 o_y_cnt SHALL be aligned with o_de (the same 2-cycle delay).
REQ-024 i_hsync low mid-word SHALL discard the partial word without emitting it and clear beat_cnt.
REQ-025 i_vsync low SHALL clear the y counter, x counter and beat_cnt in the same cycle.

Reset
REQ-026 On i_rstn low, all outputs, counters, beat_cnt and delay registers SHALL go to 0 asynchronously.
REQ-027 After reset release, output SHALL begin correctly at the next i_vsync rising edge; a partially received frame SHALL not corrupt later frames.

Structure
REQ-028 Package video_pkg SHALL hold the bayer_pattern_e enum (RGGB, GRBG, GBRG, BGGR) and the colour-select function (pattern, y0, x0) -> {R,G,B}.
REQ-029 The gearbox SHALL be a sub-module pixel_pack (parameters PW, IN_PCNT, OUT_PCNT; inputs push, last, data; outputs valid, word).
REQ-030 No line buffer or RAM SHALL be used.

Verification
REQ-031 GBRG, 8x2 frame, all beats valid, R=0x11 G=0x22 B=0x33 -> line0 words 0x33223322 twice, line1 0x22112211 twice, each 2 cycles after the completing beat.
REQ-032 RGGB, i_valid toggling 1-0-1-0 on line 0 -> same words as a gap-free run, with o_valid 2 cycles after every second valid beat.
REQ-033 HRES=6, GBRG, line 0 -> second word 0x00003322 flushed with o_valid while o_de=1, then o_de=0 next cycle.
REQ-034 i_hsync dropped after one beat of a word -> no o_valid for that word; next line's first word correct.
REQ-035 i_rstn pulsed mid-line -> all outputs 0 immediately; the next full frame matches the REQ-031 golden output.
REQ-036 All four PATTERN values over 4x4 ramp data -> o_raw matches the reference model exactly; o_y_cnt = 0..3.

Source files
------------

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Bayer pattern enum and per-site colour selection helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package video_pkg;

    typedef enum logic [1:0] {
        RGGB = 2'd0,
        GRBG = 2'd1,
        GBRG = 2'd2,
        BGGR = 2'd3
    } bayer_pattern_e;

    typedef enum logic [1:0] {
        COL_R = 2'd0,
        COL_G = 2'd1,
        COL_B = 2'd2
    } colour_e;

    // Unrecognised strings fall back to GBRG, the block's default sensor layout.
    function automatic bayer_pattern_e pattern_from_str(input logic [31:0] s);
        case (s)
            "RGGB":  return RGGB;
            "GRBG":  return GRBG;
            "BGGR":  return BGGR;
            default: return GBRG;
        endcase
    endfunction

    function automatic colour_e bayer_colour(input bayer_pattern_e pat,
                                             input logic y0, input logic x0);
        colour_e c;
        c = COL_G;
        case (pat)
            RGGB:    c = y0 ? (x0 ? COL_B : COL_G) : (x0 ? COL_G : COL_R);
            GRBG:    c = y0 ? (x0 ? COL_G : COL_B) : (x0 ? COL_R : COL_G);
            GBRG:    c = y0 ? (x0 ? COL_G : COL_R) : (x0 ? COL_B : COL_G);
            BGGR:    c = y0 ? (x0 ? COL_R : COL_G) : (x0 ? COL_G : COL_B);
            default: c = COL_G;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_pack.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_pack
//  Description : Gearbox packing IN_PCNT-sample beats into OUT_PCNT-sample words.
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_pack #(
    parameter int PW       = 8,
    parameter int IN_PCNT  = 2,
    parameter int OUT_PCNT = 4
) (
    input  logic                     i_pclk,
    input  logic                     i_rstn,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     last,
    input  logic [PW*IN_PCNT-1:0]    data,
    output logic                     valid,
    output logic [PW*OUT_PCNT-1:0]   word
);

    localparam int c_beats = OUT_PCNT / IN_PCNT;
    localparam int c_in_w  = PW * IN_PCNT;
    localparam int c_cw    = (c_beats > 1) ? $clog2(c_beats) : 1;

    logic [c_cw-1:0]          r_cnt;
    logic [PW*OUT_PCNT-1:0]   r_acc;
    logic [PW*OUT_PCNT-1:0]   r_done_word;
    logic                     r_done;
    logic [PW*OUT_PCNT-1:0]   w_fill;
    logic                     w_last_slot;
    logic                     w_flush;

    always_comb begin
        w_fill = r_acc;
        for (int b = 0; b < c_beats; b++) begin
            if (r_cnt == c_cw'(b)) begin
                w_fill[b*c_in_w +: c_in_w] = data;
            end
        end
    end

    assign w_last_slot = (r_cnt == c_cw'(c_beats - 1));
    assign w_flush     = last && (r_cnt != '0) && !clear;

    // Completed words go through r_done_word so the next beat can start
    // refilling r_acc in the very next cycle without clobbering the output.
    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_done_word <= '0;
            r_done      <= 1'b0;
            valid       <= 1'b0;
            word        <= '0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (push) begin
                if (w_last_slot) begin
                    r_done      <= 1'b1;
                    r_done_word <= w_fill;
                    r_cnt       <= '0;
                    r_acc       <= '0;
                end else begin
                    r_acc <= w_fill;
                    r_cnt <= r_cnt + c_cw'(1);
                end
            end else if (w_flush) begin
                r_cnt <= '0;
                r_acc <= '0;
            end

            valid <= r_done || w_flush;
            if (r_done) begin
                word <= r_done_word;
            end else if (w_flush) begin
                word <= r_acc;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb2raw.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2raw
//  Description : Converts multi-pixel RGB beats into packed Bayer raw words.
//  Revision    : 1.0  initial release
// ============================================================================
module rgb2raw
    import video_pkg::*;
#(
    parameter int          PW       = 8,
    parameter int          IN_PCNT  = 2,
    parameter int          OUT_PCNT = 4,
    parameter int          MAX_HRES = 1920,
    parameter int          MAX_VRES = 1080,
    parameter logic [31:0] PATTERN  = "GBRG"
) (
    input  logic                          i_pclk,
    input  logic                          i_rstn,
    input  logic                          i_vsync,
    input  logic                          i_hsync,
    input  logic                          i_de,
    input  logic                          i_valid,
    input  logic [PW*IN_PCNT-1:0]         i_r,
    input  logic [PW*IN_PCNT-1:0]         i_g,
    input  logic [PW*IN_PCNT-1:0]         i_b,
    output logic                          o_vsync,
    output logic                          o_hsync,
    output logic                          o_de,
    output logic                          o_valid,
    output logic [PW*OUT_PCNT-1:0]        o_raw,
    output logic [$clog2(MAX_VRES)-1:0]   o_y_cnt
);

    localparam int             c_xw      = $clog2(MAX_HRES);
    localparam int             c_yw      = $clog2(MAX_VRES);
    localparam bayer_pattern_e c_pattern = pattern_from_str(PATTERN);

    logic [c_xw-1:0]        r_x;
    logic [c_yw-1:0]        r_y;
    logic [c_yw-1:0]        r_y_d1;
    logic                   r_de_prev;
    logic [2:0]             r_sync_d1;
    logic [2:0]             r_sync_d2;
    logic                   w_beat;
    logic                   w_de_fall;
    logic                   w_clear;
    logic [PW*IN_PCNT-1:0]  w_samples;

    assign w_beat    = i_de && i_valid;
    assign w_de_fall = r_de_prev && !i_de;
    assign w_clear   = !i_vsync || !i_hsync;

    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_x       <= '0;
            r_y       <= '0;
            r_de_prev <= 1'b0;
        end else begin
            r_de_prev <= i_de;
            if (w_clear) begin
                r_x <= '0;
            end else if (w_beat) begin
                r_x <= r_x + c_xw'(IN_PCNT);
            end
            if (!i_vsync) begin
                r_y <= '0;
            end else if (w_de_fall) begin
                r_y <= r_y + c_yw'(1);
            end
        end
    end

    // Only the parity of x and y matters for the Bayer site of each pixel.
    for (genvar k = 0; k < IN_PCNT; k++) begin : g_pix
        logic    w_x0;
        colour_e w_sel;
        assign w_x0  = r_x[0] ^ (k % 2 == 1);
        assign w_sel = bayer_colour(c_pattern, r_y[0], w_x0);
        assign w_samples[k*PW +: PW] = (w_sel == COL_R) ? i_r[k*PW +: PW] :
                                       (w_sel == COL_B) ? i_b[k*PW +: PW] :
                                                          i_g[k*PW +: PW];
    end

    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync_d1 <= '0;
            r_sync_d2 <= '0;
            r_y_d1    <= '0;
            o_y_cnt   <= '0;
        end else begin
            r_sync_d1 <= {i_vsync, i_hsync, i_de};
            r_sync_d2 <= r_sync_d1;
            r_y_d1    <= r_y;
            o_y_cnt   <= r_y_d1;
        end
    end

    assign {o_vsync, o_hsync, o_de} = r_sync_d2;

    pixel_pack #(
        .PW       (PW),
        .IN_PCNT  (IN_PCNT),
        .OUT_PCNT (OUT_PCNT)
    ) u_pack (
        .i_pclk (i_pclk),
        .i_rstn (i_rstn),
        .clear  (w_clear),
        .push   (w_beat),
        .last   (w_de_fall),
        .data   (w_samples),
        .valid  (o_valid),
        .word   (o_raw)
    );

endmodule
`default_nettype wire

// File: tb/tb_rgb2raw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb2raw
//  Description : Self-checking bench; one DUT per Bayer pattern on shared stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rgb2raw;

    localparam int MAXC = 1024;

    typedef struct {
        logic        vs, hs, de, va;
        logic [15:0] r, g, b;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vs, hs, de, va;
    logic [15:0] r, g, b;

    logic [3:0]        o_vs_w, o_hs_w, o_de_w, o_va_w;
    logic [3:0][31:0]  o_raw_w;
    logic [3:0][10:0]  o_y_w;

    always #5 clk = ~clk;

    for (genvar p = 0; p < 4; p++) begin : g_dut
        localparam logic [31:0] c_pat = (p == 0) ? "RGGB" : (p == 1) ? "GRBG" :
                                        (p == 2) ? "GBRG" : "BGGR";
        rgb2raw #(
            .PW(8), .IN_PCNT(2), .OUT_PCNT(4),
            .MAX_HRES(1920), .MAX_VRES(1080), .PATTERN(c_pat)
        ) u_dut (
            .i_pclk  (clk),
            .i_rstn  (rstn),
            .i_vsync (vs),
            .i_hsync (hs),
            .i_de    (de),
            .i_valid (va),
            .i_r     (r),
            .i_g     (g),
            .i_b     (b),
            .o_vsync (o_vs_w[p]),
            .o_hsync (o_hs_w[p]),
            .o_de    (o_de_w[p]),
            .o_valid (o_va_w[p]),
            .o_raw   (o_raw_w[p]),
            .o_y_cnt (o_y_w[p])
        );
    end

    int           n_checks = 0;
    int           n_fail   = 0;
    cyc_t         stim[$];
    logic [2:0]   ex_sync[MAXC];
    logic [10:0]  ex_y[MAXC];
    logic         ex_va[4][MAXC];
    logic [31:0]  ex_raw[4][MAXC];
    logic [31:0]  held_raw[4];
    logic [31:0]  got_words[$];
    logic [10:0]  got_y[$];

    function automatic logic [31:0] pat_str(input int p);
        case (p)
            0:       return "RGGB";
            1:       return "GRBG";
            2:       return "GBRG";
            default: return "BGGR";
        endcase
    endfunction

    task automatic push_data(input logic v, input logic h, input logic d, input logic a,
                             input logic [15:0] rr, input logic [15:0] gg, input logic [15:0] bb);
        cyc_t c;
        c.vs = v; c.hs = h; c.de = d; c.va = a; c.r = rr; c.g = gg; c.b = bb;
        stim.push_back(c);
    endtask

    task automatic push_cyc(input logic v, input logic h, input logic d, input logic a);
        push_data(v, h, d, a, 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // gap: 0 none, 1 invalid beat after each valid beat, 2 random invalid beats.
    // dmode: 0 flat 11/22/33, 1 ramp, 2 random.
    task automatic add_line(input int beats, input int gap, input int dmode,
                            input int line, input bit drop);
        logic [15:0] rr, gg, bb;
        push_cyc(1, 1, 0, 0);
        push_cyc(1, 1, 0, 0);
        for (int i = 0; i < beats; i++) begin
            if (gap == 2) begin
                int ng;
                ng = $urandom_range(0, 2);
                for (int j = 0; j < ng; j++) push_cyc(1, 1, 1, 0);
            end
            for (int k = 0; k < 2; k++) begin
                int x;
                x = 2 * i + k;
                case (dmode)
                    0: begin
                        rr[k*8 +: 8] = 8'h11; gg[k*8 +: 8] = 8'h22; bb[k*8 +: 8] = 8'h33;
                    end
                    1: begin
                        rr[k*8 +: 8] = 8'(line * 16 + x);
                        gg[k*8 +: 8] = 8'(8'h40 + line * 16 + x);
                        bb[k*8 +: 8] = 8'(8'h80 + line * 16 + x);
                    end
                    default: begin
                        rr[k*8 +: 8] = 8'($urandom); gg[k*8 +: 8] = 8'($urandom);
                        bb[k*8 +: 8] = 8'($urandom);
                    end
                endcase
            end
            push_data(1, 1, 1, 1, rr, gg, bb);
            if (gap == 1) push_cyc(1, 1, 1, 0);
        end
        if (drop) begin
            push_cyc(1, 0, 0, 0);
            push_cyc(1, 0, 0, 0);
        end else begin
            push_cyc(1, 1, 0, 0);
            push_cyc(1, 1, 0, 0);
            push_cyc(1, 0, 0, 0);
            push_cyc(1, 0, 0, 0);
        end
    endtask

    task automatic begin_frame();
        for (int i = 0; i < 3; i++) push_cyc(0, 0, 0, 0);
        push_cyc(1, 0, 0, 0);
        push_cyc(1, 0, 0, 0);
    endtask

    task automatic end_frame();
        for (int i = 0; i < 3; i++) push_cyc(0, 0, 0, 0);
    endtask

    // Reference model: pixels are collected per line in arrival order, the
    // colour is read from the pattern string at character (2*y0 + x0).
    task automatic build_expect();
        int N;
        N = stim.size();
        for (int c = 0; c < N + 2; c++) begin
            ex_sync[c] = 3'b000;
            ex_y[c]    = '0;
            for (int p = 0; p < 4; p++) begin
                ex_va[p][c]  = 1'b0;
                ex_raw[p][c] = '0;
            end
        end
        for (int p = 0; p < 4; p++) begin
            int          n, xc, y;
            logic        dp;
            logic [31:0] word, ps;
            n = 0; xc = 0; y = 0; dp = 1'b0; word = '0; ps = pat_str(p);
            for (int c = 0; c < N; c++) begin
                cyc_t s;
                s = stim[c];
                if (p == 0) begin
                    ex_sync[c+2] = {s.vs, s.hs, s.de};
                    ex_y[c+2]    = 11'(y);
                end
                if (!s.vs || !s.hs) begin
                    n = 0; xc = 0; word = '0;
                end else if (dp && !s.de && n > 0) begin
                    ex_va[p][c+1]  = 1'b1;
                    ex_raw[p][c+1] = word;
                    n = 0; word = '0;
                end
                if (!s.vs) y = 0;
                else if (dp && !s.de) y = y + 1;
                if (s.de && s.va) begin
                    for (int k = 0; k < 2; k++) begin
                        int         x, idx;
                        logic [7:0] ch, smp;
                        x   = xc + k;
                        idx = (y % 2) * 2 + (x % 2);
                        ch  = ps[31 - 8*idx -: 8];
                        if (ch == "R")      smp = s.r[k*8 +: 8];
                        else if (ch == "B") smp = s.b[k*8 +: 8];
                        else                smp = s.g[k*8 +: 8];
                        word[n*8 +: 8] = smp;
                        n = n + 1;
                    end
                    xc = xc + 2;
                    if (n == 4) begin
                        ex_va[p][c+2]  = 1'b1;
                        ex_raw[p][c+2] = word;
                        n = 0; word = '0;
                    end
                end
                dp = s.de;
            end
            for (int c = 0; c < N + 2; c++) begin
                if (ex_va[p][c]) held_raw[p] = ex_raw[p][c];
                else             ex_raw[p][c] = held_raw[p];
            end
        end
    endtask

    task automatic run_stim(input string tag);
        int N;
        push_cyc(0, 0, 0, 0);
        push_cyc(0, 0, 0, 0);
        N = stim.size();
        if (N + 2 > MAXC) begin
            $display("FAIL %s stimulus too long len=%0d limit=%0d", tag, N, MAXC);
            n_fail++;
            $fatal(1, "stimulus overflow");
        end
        build_expect();
        got_words.delete();
        got_y.delete();
        for (int c = 0; c < N + 2; c++) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 4; p++) begin
                n_checks++;
                if ({o_vs_w[p], o_hs_w[p], o_de_w[p]} !== ex_sync[c]) begin
                    n_fail++;
                    $display("FAIL %s syncs cyc=%0d dut=%0d got=%b exp=%b", tag, c, p,
                             {o_vs_w[p], o_hs_w[p], o_de_w[p]}, ex_sync[c]);
                end
                n_checks++;
                if (o_va_w[p] !== ex_va[p][c]) begin
                    n_fail++;
                    $display("FAIL %s o_valid cyc=%0d dut=%0d got=%b exp=%b", tag, c, p,
                             o_va_w[p], ex_va[p][c]);
                end
                n_checks++;
                if (o_raw_w[p] !== ex_raw[p][c]) begin
                    n_fail++;
                    $display("FAIL %s o_raw cyc=%0d dut=%0d got=%h exp=%h", tag, c, p,
                             o_raw_w[p], ex_raw[p][c]);
                end
                n_checks++;
                if (o_y_w[p] !== ex_y[c]) begin
                    n_fail++;
                    $display("FAIL %s o_y_cnt cyc=%0d dut=%0d got=%0d exp=%0d", tag, c, p,
                             o_y_w[p], ex_y[c]);
                end
            end
            if (o_va_w[2] === 1'b1) begin
                got_words.push_back(o_raw_w[2]);
                got_y.push_back(o_y_w[2]);
            end
            if (c < N) begin
                vs = stim[c].vs; hs = stim[c].hs; de = stim[c].de; va = stim[c].va;
                r = stim[c].r; g = stim[c].g; b = stim[c].b;
            end else begin
                vs = 0; hs = 0; de = 0; va = 0;
            end
        end
        stim.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        vs = 0; hs = 0; de = 0; va = 0; r = '0; g = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if ({o_vs_w[p], o_hs_w[p], o_de_w[p], o_va_w[p]} !== 4'b0000 ||
                o_raw_w[p] !== 32'h0 || o_y_w[p] !== 11'h0) begin
                n_fail++;
                $display("FAIL reset_state dut=%0d got=%b/%h/%0d exp=0", p,
                         {o_vs_w[p], o_hs_w[p], o_de_w[p], o_va_w[p]}, o_raw_w[p], o_y_w[p]);
            end
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_golden_frame(input string tag);
        logic [31:0] gold[4];
        gold = '{32'h33223322, 32'h33223322, 32'h22112211, 32'h22112211};
        begin_frame();
        add_line(4, 0, 0, 0, 1'b0);
        add_line(4, 0, 0, 1, 1'b0);
        end_frame();
        run_stim(tag);
        n_checks++;
        if (got_words.size() != 4) begin
            n_fail++;
            $display("FAIL %s word_count got=%0d exp=4", tag, got_words.size());
        end
        for (int i = 0; i < 4 && i < got_words.size(); i++) begin
            n_checks++;
            if (got_words[i] !== gold[i]) begin
                n_fail++;
                $display("FAIL %s golden_word%0d got=%h exp=%h", tag, i, got_words[i], gold[i]);
            end
        end
    endtask

    task automatic test_valid_gaps();
        begin_frame();
        add_line(4, 1, 2, 0, 1'b0);
        add_line(4, 2, 2, 1, 1'b0);
        end_frame();
        run_stim("valid_gaps");
        n_checks++;
        if (got_words.size() != 4) begin
            n_fail++;
            $display("FAIL valid_gaps word_count got=%0d exp=4", got_words.size());
        end
    endtask

    task automatic test_flush();
        logic [31:0] gold[4];
        gold = '{32'h33223322, 32'h00003322, 32'h22112211, 32'h00002211};
        begin_frame();
        add_line(3, 0, 0, 0, 1'b0);
        add_line(3, 0, 0, 1, 1'b0);
        end_frame();
        run_stim("flush");
        n_checks++;
        if (got_words.size() != 4) begin
            n_fail++;
            $display("FAIL flush word_count got=%0d exp=4", got_words.size());
        end
        for (int i = 0; i < 4 && i < got_words.size(); i++) begin
            n_checks++;
            if (got_words[i] !== gold[i]) begin
                n_fail++;
                $display("FAIL flush word%0d got=%h exp=%h", i, got_words[i], gold[i]);
            end
        end
    endtask

    task automatic test_hsync_drop();
        begin_frame();
        add_line(1, 0, 0, 0, 1'b1);
        add_line(4, 0, 0, 1, 1'b0);
        end_frame();
        run_stim("hsync_drop");
        n_checks++;
        if (got_words.size() != 2) begin
            n_fail++;
            $display("FAIL hsync_drop word_count got=%0d exp=2", got_words.size());
        end
        for (int i = 0; i < 2 && i < got_words.size(); i++) begin
            n_checks++;
            if (got_words[i] !== 32'h22112211) begin
                n_fail++;
                $display("FAIL hsync_drop word%0d got=%h exp=22112211", i, got_words[i]);
            end
        end
    endtask

    task automatic test_reset_midline();
        @(posedge clk); #1;
        vs = 1; hs = 0; de = 0; va = 0;
        @(posedge clk); #1;
        hs = 1;
        @(posedge clk); #1;
        de = 1; va = 1; r = 16'h1111; g = 16'h2222; b = 16'h3333;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if ({o_vs_w[p], o_hs_w[p], o_de_w[p], o_va_w[p]} !== 4'b0000 ||
                o_raw_w[p] !== 32'h0 || o_y_w[p] !== 11'h0) begin
                n_fail++;
                $display("FAIL reset_midline dut=%0d got=%b/%h/%0d exp=0", p,
                         {o_vs_w[p], o_hs_w[p], o_de_w[p], o_va_w[p]}, o_raw_w[p], o_y_w[p]);
            end
            held_raw[p] = '0;
        end
        vs = 0; hs = 0; de = 0; va = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        test_golden_frame("after_reset");
    endtask

    task automatic test_ramp_patterns();
        begin_frame();
        for (int l = 0; l < 4; l++) add_line(2, 0, 1, l, 1'b0);
        end_frame();
        run_stim("ramp");
        n_checks++;
        if (got_y.size() != 4) begin
            n_fail++;
            $display("FAIL ramp word_count got=%0d exp=4", got_y.size());
        end
        for (int i = 0; i < 4 && i < got_y.size(); i++) begin
            n_checks++;
            if (got_y[i] !== 11'(i)) begin
                n_fail++;
                $display("FAIL ramp y_line%0d got=%0d exp=%0d", i, got_y[i], i);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            int nl;
            nl = $urandom_range(1, 4);
            begin_frame();
            for (int l = 0; l < nl; l++) begin
                add_line($urandom_range(1, 6), 2, 2, l, ($urandom_range(0, 4) == 0));
            end
            end_frame();
            run_stim("random");
        end
    endtask

    initial begin
        for (int p = 0; p < 4; p++) held_raw[p] = '0;
        test_reset();
        test_golden_frame("golden");
        test_valid_gaps();
        test_flush();
        test_hsync_drop();
        test_reset_midline();
        test_ramp_patterns();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
